// File: rtl/rvfi_trace_sink.sv
// rvfi_trace_sink: receiving end of the core's RVFI retirement port.
// Each rvfi_valid cycle produces one record. The record is optionally
// checked, then stored in a record FIFO. Each record is emitted as six
// 32-bit words on a valid/ready stream.
// The core is never stalled. When the FIFO is full, the record is dropped
// and the drop is counted.
//
// Optional feature macro: RVFI_SINK_CHECK_EN
//   When defined, pc-continuity and x0-write checks are enabled.
//
// Ports:
//   clock, reset       single clock; asynchronous active-low reset
//   rvfi_*             retirement record inputs (one per rvfi_valid cycle)
//   out_valid/out_ready/out_data/out_last
//                      record word stream; out_last marks word 5
//   clear              synchronous clear of status counters and flags
//   drop_count/overflow
//                      saturating drop counter and sticky drop flag
//   err_count/check_err
//                      saturating check-error counter and sticky error flag
module rvfi_trace_sink #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rvfi_valid,
  input  logic [31:0] rvfi_insn,
  input  logic [4:0]  rvfi_rs1_addr,
  input  logic [4:0]  rvfi_rs2_addr,
  input  logic [4:0]  rvfi_rd_addr,
  input  logic [31:0] rvfi_rd_wdata,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic [31:0] rvfi_pc_wdata,
  input  logic [31:0] rvfi_mem_addr,
  input  logic [3:0]  rvfi_mem_wmask,
  input  logic [31:0] rvfi_mem_rdata,
  input  logic [31:0] rvfi_mem_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  input  logic        clear,
  output logic [15:0] drop_count,
  output logic        overflow,
  output logic [15:0] err_count,
  output logic        check_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [2:0] LAST_IDX = 3'd5;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t state, state_nx;

  logic [5:0][31:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, occupancy;
  logic [2:0]       idx;
  logic [10:0]      seq;
  logic             full, hs, pop, push, drop;
  logic             pc_err, x0_err;
  logic [31:0]      hdr, w5;

  assign occupancy = wr_ptr - rd_ptr;
  assign full      = (occupancy == (AW+1)'(DEPTH));
  assign out_valid = (state == STREAM);
  assign hs        = out_valid && out_ready;
  assign pop       = hs && (idx == LAST_IDX);
  // A full FIFO still accepts a record when its head retires on this edge.
  assign push      = rvfi_valid && (!full || pop);
  assign drop      = rvfi_valid && full && !pop;

  assign out_data  = out_valid ? mem[rd_ptr[AW-1:0]][idx] : '0;
  assign out_last  = out_valid && (idx == LAST_IDX);

  assign hdr = {rvfi_rd_addr, rvfi_rs1_addr, rvfi_rs2_addr, rvfi_mem_wmask,
                pc_err, x0_err, seq};
  assign w5  = (rvfi_mem_wmask != 4'd0) ? rvfi_mem_wdata : rvfi_mem_rdata;

  // State tracks FIFO occupancy: STREAM exactly while a record is present.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (push) state_nx = STREAM;
      STREAM:  if (pop && !push && (occupancy == (AW+1)'(1))) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Record storage is not reset. Pointer reset discards the contents.
  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= {w5, rvfi_mem_addr, rvfi_rd_wdata, rvfi_insn,
                              rvfi_pc_rdata, hdr};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      idx    <= '0;
      seq    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (hs)   idx    <= (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
      // seq advances on dropped records too, so drops show as gaps.
      if (rvfi_valid) seq <= seq + 11'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (clear) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + 16'd1;
    end
  end

`ifdef RVFI_SINK_CHECK_EN
  logic [31:0] prev_pc;
  logic        have_prev;

  assign pc_err = have_prev && (rvfi_pc_rdata != prev_pc);
  assign x0_err = (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_pc   <= '0;
      have_prev <= 1'b0;
    end else if (rvfi_valid) begin
      prev_pc   <= rvfi_pc_wdata;
      have_prev <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
      check_err <= 1'b0;
    end else if (clear) begin
      err_count <= '0;
      check_err <= 1'b0;
    end else if (rvfi_valid && (pc_err || x0_err)) begin
      check_err <= 1'b1;
      if (err_count != '1) err_count <= err_count + 16'd1;
    end
  end
`else
  logic unused_pc_wdata;

  assign pc_err          = 1'b0;
  assign x0_err          = 1'b0;
  assign err_count       = '0;
  assign check_err       = 1'b0;
  assign unused_pc_wdata = ^rvfi_pc_wdata;
`endif

endmodule

// File: tb/tb_rvfi_trace_sink.sv
module tb_rvfi_trace_sink;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rvfi_valid = 1'b0;
  logic [31:0] rvfi_insn = '0;
  logic [4:0]  rvfi_rs1_addr = '0;
  logic [4:0]  rvfi_rs2_addr = '0;
  logic [4:0]  rvfi_rd_addr = '0;
  logic [31:0] rvfi_rd_wdata = '0;
  logic [31:0] rvfi_pc_rdata = '0;
  logic [31:0] rvfi_pc_wdata = '0;
  logic [31:0] rvfi_mem_addr = '0;
  logic [3:0]  rvfi_mem_wmask = '0;
  logic [31:0] rvfi_mem_rdata = '0;
  logic [31:0] rvfi_mem_wdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        clear = 1'b0;
  logic [15:0] drop_count;
  logic        overflow;
  logic [15:0] err_count;
  logic        check_err;

  rvfi_trace_sink #(.DEPTH(8)) dut (
    .clock(clock), .reset(reset), .rvfi_valid(rvfi_valid), .rvfi_insn(rvfi_insn),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_wmask(rvfi_mem_wmask),
    .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .clear(clear), .drop_count(drop_count),
    .overflow(overflow), .err_count(err_count), .check_err(check_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] insn;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd_wdata, pc_rdata, pc_wdata, mem_addr;
    logic [3:0]  wmask;
    logic [31:0] mem_rdata, mem_wdata;
  } rec_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int unsigned m_seq = 0;
  logic [31:0] m_prev_pc = '0;
  bit          m_have_prev = 0;
  int          m_drop = 0;
  int          m_err = 0;
  int          word_no = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drives one retirement for one cycle. Expected words are queued only if
  // the directed step says the record is accepted.
  task automatic send(input rec_t r, input bit accept);
    logic        pe, xe;
    logic [10:0] s;
    logic [31:0] w [6];
    s = m_seq[10:0];
`ifdef RVFI_SINK_CHECK_EN
    pe = m_have_prev && (r.pc_rdata != m_prev_pc);
    xe = (r.rd == 5'd0) && (r.rd_wdata != 32'd0);
`else
    pe = 1'b0;
    xe = 1'b0;
`endif
    m_prev_pc   = r.pc_wdata;
    m_have_prev = 1;
    m_seq       = (m_seq + 1) % 2048;
    if (pe || xe) m_err++;
    w[0] = {r.rd, r.rs1, r.rs2, r.wmask, pe, xe, s};
    w[1] = r.pc_rdata;
    w[2] = r.insn;
    w[3] = r.rd_wdata;
    w[4] = r.mem_addr;
    w[5] = (r.wmask != 4'd0) ? r.mem_wdata : r.mem_rdata;
    if (accept) begin
      for (int i = 0; i < 6; i++) q.push_back('{data: w[i], last: (i == 5)});
    end else begin
      m_drop++;
    end
    rvfi_insn      = r.insn;
    rvfi_rs1_addr  = r.rs1;
    rvfi_rs2_addr  = r.rs2;
    rvfi_rd_addr   = r.rd;
    rvfi_rd_wdata  = r.rd_wdata;
    rvfi_pc_rdata  = r.pc_rdata;
    rvfi_pc_wdata  = r.pc_wdata;
    rvfi_mem_addr  = r.mem_addr;
    rvfi_mem_wmask = r.wmask;
    rvfi_mem_rdata = r.mem_rdata;
    rvfi_mem_wdata = r.mem_wdata;
    rvfi_valid     = 1'b1;
    @(posedge clock);
    #1;
    rvfi_valid = 1'b0;
  endtask

  task automatic wait_drain(input int unsigned lim);
    int unsigned n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < lim) begin
      @(posedge clock);
      #1;
      n++;
    end
    total++;
    assert (q.size() == 0 && !out_valid) else begin
      bad++;
      $error("FAIL drain_timeout observed=%0d_words_left expected=0", q.size());
    end
  endtask

  function automatic rec_t mk(input int unsigned i);
    rec_t r;
    r.insn      = 32'h00000013 + (i << 20);
    r.rs1       = 5'd1;
    r.rs2       = 5'd2;
    r.rd        = 5'd3;
    r.rd_wdata  = 32'h100 + i;
    r.pc_rdata  = 32'h80000100 + 4 * i;
    r.pc_wdata  = 32'h80000104 + 4 * i;
    r.mem_addr  = 32'h2000 + i;
    r.wmask     = 4'd0;
    r.mem_rdata = 32'hC0DE0000 + i;
    r.mem_wdata = 32'h0;
    return r;
  endfunction

  // Stream monitor: at each negedge, a word that will be handshaken on the
  // next edge is checked against the front of the scoreboard.
  always @(negedge clock) begin : mon
    exp_t e;
    if (reset && out_valid && out_ready) begin
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_word observed=%h expected=none", out_data);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk($sformatf("word%0d_data", word_no), out_data, e.data);
        chk($sformatf("word%0d_last", word_no), {31'd0, out_last}, {31'd0, e.last});
        word_no++;
      end
    end
  end

  initial begin
    rec_t r1, r2, r3;
    r1 = '{insn: 32'h00500093, rs1: 5'd0, rs2: 5'd0, rd: 5'd1, rd_wdata: 32'd5,
           pc_rdata: 32'h80000000, pc_wdata: 32'h80000004, mem_addr: 32'd0,
           wmask: 4'd0, mem_rdata: 32'hAA, mem_wdata: 32'd0};
    r2 = '{insn: 32'h00112023, rs1: 5'd2, rs2: 5'd1, rd: 5'd0, rd_wdata: 32'd0,
           pc_rdata: 32'h80000010, pc_wdata: 32'h80000014, mem_addr: 32'h1000,
           wmask: 4'hF, mem_rdata: 32'hDEADBEEF, mem_wdata: 32'h12345678};
    r3 = '{insn: 32'h00300013, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, rd_wdata: 32'd3,
           pc_rdata: 32'h80000014, pc_wdata: 32'h80000018, mem_addr: 32'd0,
           wmask: 4'd0, mem_rdata: 32'h0, mem_wdata: 32'd0};

    // Reset state
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_drop", {16'd0, drop_count}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_err", {16'd0, err_count}, 32'd0);
    chk("rst_chk", {31'd0, check_err}, 32'd0);
    reset = 1'b1;
    step(1);

    // Single record, one-cycle latency to W0
    out_ready = 1'b1;
    send(r1, 1);
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_w0", out_data, 32'h08000000);
    wait_drain(20);

    // Store record selects mem_wdata; pc gap and x0 write exercise checks
    send(r2, 1);
    wait_drain(20);
    chk("err_cnt_a", {16'd0, err_count}, m_err);
    chk("chk_err_a", {31'd0, check_err}, {31'd0, m_err != 0});
    send(r3, 1);
    wait_drain(20);
    chk("err_cnt_b", {16'd0, err_count}, m_err);
    chk("chk_err_b", {31'd0, check_err}, {31'd0, m_err != 0});

    // Overflow: 10 back-to-back records into a stalled 8-deep FIFO
    out_ready = 1'b0;
    m_seq = 0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    m_have_prev = 0;
    m_prev_pc = '0;
    m_err = 0;
    step(1);
    for (int unsigned i = 0; i < 10; i++) send(mk(i), i < 8);
    step(2);
    chk("hold_valid", {31'd0, out_valid}, 32'd1);
    chk("hold_w0_a", out_data, q[0].data);
    step(3);
    chk("hold_w0_b", out_data, q[0].data);
    chk("ovf_drop", {16'd0, drop_count}, 32'd2);
    chk("ovf_drop_m", {16'd0, drop_count}, m_drop);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_err", {16'd0, err_count}, m_err);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    m_drop = 0;
    m_err = 0;
    chk("clr_drop", {16'd0, drop_count}, 32'd0);
    chk("clr_ovf", {31'd0, overflow}, 32'd0);
    chk("clr_err", {16'd0, err_count}, 32'd0);
    chk("clr_chk", {31'd0, check_err}, 32'd0);
    chk("clr_keep", {31'd0, out_valid}, 32'd1);

    // Full FIFO: push coincides with the last-word handshake of the head
    out_ready = 1'b1;
    step(5);
    chk("coinc_last", {31'd0, out_last}, 32'd1);
    send(mk(10), 1);
    chk("coinc_drop", {16'd0, drop_count}, 32'd0);
    chk("coinc_ovf", {31'd0, overflow}, 32'd0);
    wait_drain(100);

    // Reset during W3 aborts the stream and discards the FIFO
    out_ready = 1'b0;
    send(r1, 1);
    out_ready = 1'b1;
    step(3);
    out_ready = 1'b0;
    chk("pre_rst_w3", out_data, q[0].data);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_last", {31'd0, out_last}, 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    q.delete();
    m_seq = 0;
    m_have_prev = 0;
    m_prev_pc = '0;
    m_drop = 0;
    m_err = 0;
    step(2);
    #3;
    reset = 1'b1;
    step(1);
    chk("post_rst_empty", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    send(r1, 1);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_w0", out_data, 32'h08000000);
    wait_drain(20);
    chk("end_drop", {16'd0, drop_count}, m_drop);
    chk("end_err", {16'd0, err_count}, m_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rvfi_trace_sink.md
Name: rvfi_trace_sink

Overview:
- Receiving end of the core's RVFI retirement port; consumes one retirement record per cycle from the tracer outputs.
- Optionally checks each record for consistency, then buffers it in a record FIFO.
- Serializes each record as a 6-word, 32-bit valid/ready stream to the debug/trace export path.
- The core cannot be stalled by RVFI. On a full FIFO the record is dropped and counted.

Parameters:
- DEPTH, 8, FIFO depth in records; power of 2, minimum 2.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rvfi_valid  in  1  retirement strobe.
- rvfi_insn  in  32  retired instruction.
- rvfi_rs1_addr  in  5  rs1 index.
- rvfi_rs2_addr  in  5  rs2 index.
- rvfi_rd_addr  in  5  rd index.
- rvfi_rd_wdata  in  32  rd write data.
- rvfi_pc_rdata  in  32  pc of retired instruction.
- rvfi_pc_wdata  in  32  next pc.
- rvfi_mem_addr  in  32  memory address.
- rvfi_mem_wmask  in  4  store byte mask; 0 = no store.
- rvfi_mem_rdata  in  32  load data.
- rvfi_mem_wdata  in  32  store data.
- out_valid  out  1  stream word valid.
- out_ready  in  1  stream word accept.
- out_data  out  32  stream word.
- out_last  out  1  high on word 5 of a record.
- clear  in  1  synchronous clear of status counters and flags.
- drop_count  out  16  saturating count of dropped records.
- overflow  out  1  sticky; a record was dropped.
- err_count  out  16  saturating count of records with any check error.
- check_err  out  1  sticky; a check error was seen.

Behaviour:
- Reset values:
  - All outputs 0.
  - FIFO empty; word index 0; seq 0; have_prev 0; prev_pc 0.
- Assertion of reset mid-record:
  - Aborts the stream immediately.
  - out_valid goes low asynchronously.
  - FIFO contents are discarded.
- seq (11 bits):
  - Increments on every rvfi_valid cycle, accepted or dropped, so drops appear as gaps.
  - Wraps 2047 -> 0.
  - The value stored in a record is the pre-increment value.
- Push:
  - Condition: rvfi_valid && (!full || pop_this_cycle).
  - When FIFO is full and the last word of the head record is handshaken in the same cycle, the push is accepted.
- Drop:
  - Condition: rvfi_valid && full && !pop_this_cycle.
  - Action: overflow <= 1; drop_count += 1, saturating at 0xFFFF.
- Record word layout:
  - W0 header:
    - [31:27] rd_addr
    - [26:22] rs1_addr
    - [21:17] rs2_addr
    - [16:13] mem_wmask
    - [12] pc_err
    - [11] x0_err
    - [10:0] seq
  - W1 = pc_rdata.
  - W2 = insn.
  - W3 = rd_wdata.
  - W4 = mem_addr.
  - W5 = mem_wdata if mem_wmask != 0, else mem_rdata.
- Latency: a record pushed at edge N gives out_valid = 1 with W0 in cycle N+1 if the FIFO was empty.
- Serializer:
  - out_data = head record word[idx].
  - On out_valid && out_ready: idx advances.
  - At idx 5 with handshake: idx -> 0 and the head is popped.
  - out_valid = !empty.
  - out_data and out_last stay stable while out_valid && !out_ready.
- States: IDLE (empty), STREAM (idx 0..5). Transitions:
  - STREAM -> IDLE after the last-word pop when the FIFO becomes empty.
  - Otherwise STREAM continues at W0 of the next record with no bubble.
- Simultaneous push into an empty FIFO and reset deassertion: the push is honoured.
- clear:
  - Zeros drop_count, overflow, err_count and check_err.
  - Does not touch FIFO, seq or prev_pc.
  - If an increment and clear occur in the same cycle, clear wins and the result is 0.

Optional Feature:
- Macro: RVFI_SINK_CHECK_EN.
- Defined:
  - pc_err = have_prev && (pc_rdata != prev_pc).
  - x0_err = (rd_addr == 0) && (rd_wdata != 0).
  - prev_pc <= pc_wdata and have_prev <= 1 on every rvfi_valid, including dropped records; the first record after reset never flags pc_err.
  - If either error is set: check_err <= 1 and err_count += 1, saturating. This applies to dropped records too.
- Undefined:
  - Header bits [12:11] are 0.
  - err_count and check_err are tied to 0.
  - prev_pc and have_prev logic is absent.

Test Plan:
- Single record insn=0x00500093, pc_rdata=0x80000000, pc_wdata=0x80000004, rd=1, rd_wdata=5, wmask=0, mem_rdata=0xAA, out_ready=1 -> 6 words starting cycle N+1:
  - W0 = 0x08000000, seq=0.
  - W5 = 0xAA.
  - out_last only on W5.
- Store with wmask=0xF, mem_wdata=0x12345678, mem_rdata=0xDEADBEEF -> W5 = 0x12345678 and W0[16:13] = 0xF.
- out_ready=0 with DEPTH=8 and 10 consecutive valid records -> 8 buffered; drop_count=2, overflow=1; streamed headers show seq 0..7. Then pulse clear -> drop_count=0, overflow=0.
- Full FIFO, last-word handshake coinciding with rvfi_valid -> record accepted, no drop.
- With RVFI_SINK_CHECK_EN:
  - Record 2 pc_rdata=0x80000010 after pc_wdata=0x80000004 -> W0[12]=1, err_count=1, check_err=1.
  - rd=0 with rd_wdata=3 -> W0[11]=1.
- Assert reset during W3 of a record -> out_valid=0 immediately. After release: FIFO empty, next record streams W0 with seq=0.
